// File: rtl/inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// inv_cipher_iter
//
// Iterative AES-128 inverse cipher: one round per clock. The expanded round
// keys live outside the block. The block publishes the index it needs on
// rk_idx and expects the matching key on rk in the same cycle.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    launch a decryption of ct_in (sampled only while idle)
//   ct_in    128-bit ciphertext, captured on the accepting edge
//   rk       round key for rk_idx, driven combinationally by the key store
//   rk_idx   round-key index wanted this cycle (0..10)
//   pt_out   registered plaintext, held until the next block completes
//   busy     high while a block is in flight
//   done     one-cycle pulse when pt_out has just been updated
//
// Byte order: byte 0 = bits [127:120], state column-major, s[r][c] = byte 4c+r.
//
// State   | meaning
// --------+------------------------------------------------------------------
// S_IDLE  | waiting for start; rk_idx = 10 for the initial AddRoundKey
// S_ROUND | full inverse rounds 9..1; rk_idx = round counter
// S_FINAL | last round without InvMixColumns; rk_idx = 0, writes pt_out
// -----------------------------------------------------------------------------
module inv_cipher_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ct_in,
    input  logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic [127:0] pt_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    // Element 0 is the most significant byte, matching the bus byte order.
    typedef logic [0:15][7:0] blk_t;

    // Inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [10:0] lsb;
        lsb = 11'd2040 - {x, 3'b000};
        return INV_SBOX_TBL[lsb +: 8];
    endfunction

    // Multiply by x (0x02) modulo 0x11b.
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r: new s[r][c] = old s[r][(c - r) mod 4].
    function automatic blk_t inv_shift_rows(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(4 * c + r)] = s[4'(4 * ((c - r) & 3) + r)];
            end
        end
        return o;
    endfunction

    function automatic blk_t inv_sub_bytes(input blk_t s);
        blk_t o;
        for (int i = 0; i < 16; i++) begin
            o[4'(i)] = inv_sbox(s[4'(i)]);
        end
        return o;
    endfunction

    function automatic blk_t inv_mix_columns(input blk_t s);
        blk_t        o;
        logic [7:0]  a [4];
        logic [7:0]  a2 [4];
        logic [7:0]  a4 [4];
        logic [7:0]  a8 [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[4'(4 * c + r)];
                a2[r] = xt(a[r]);
                a4[r] = xt(a2[r]);
                a8[r] = xt(a4[r]);
                m9[r] = a8[r] ^ a[r];
                mb[r] = a8[r] ^ a2[r] ^ a[r];
                md[r] = a8[r] ^ a4[r] ^ a[r];
                me[r] = a8[r] ^ a4[r] ^ a2[r];
            end
            o[4'(4 * c + 0)] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[4'(4 * c + 1)] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[4'(4 * c + 2)] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[4'(4 * c + 3)] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    state_t         r_fsm;
    logic [3:0]     r_cnt;
    logic [127:0]   r_state;
    logic [127:0]   r_pt;
    logic           r_busy;
    logic           r_done;

    state_t         w_fsm_nxt;
    logic [3:0]     w_cnt_nxt;
    logic [127:0]   w_state_nxt;
    logic [127:0]   w_pt_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;
    logic [3:0]     w_rk_idx;

    blk_t           w_isr;
    blk_t           w_isb;
    blk_t           w_ark;
    blk_t           w_imc;

    // Shared round datapath: the FINAL round taps w_ark, full rounds take w_imc.
    always_comb begin
        w_isr = inv_shift_rows(r_state);
        w_isb = inv_sub_bytes(w_isr);
        w_ark = w_isb ^ rk;
        w_imc = inv_mix_columns(w_ark);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= 4'd0;
            r_state <= 128'h0;
            r_pt    <= 128'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            r_pt    <= w_pt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_pt_nxt    = r_pt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_rk_idx    = 4'd10;

        case (r_fsm)
            S_IDLE: begin
                w_rk_idx = 4'd10;
                if (start) begin
                    w_state_nxt = ct_in ^ rk;
                    w_cnt_nxt   = 4'd9;
                    w_busy_nxt  = 1'b1;
                    w_fsm_nxt   = S_ROUND;
                end
            end
            S_ROUND: begin
                w_rk_idx    = r_cnt;
                w_state_nxt = w_imc;
                w_cnt_nxt   = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_fsm_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                w_rk_idx   = 4'd0;
                w_pt_nxt   = w_ark;
                w_done_nxt = 1'b1;
                w_busy_nxt = 1'b0;
                w_fsm_nxt  = S_IDLE;
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    assign rk_idx = w_rk_idx;
    assign pt_out = r_pt;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_inv_cipher_iter.sv
module tb_inv_cipher_iter;

    typedef logic [0:15][7:0] blk_t;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int NVEC = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] ct_in;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic [127:0] pt_out;
    logic         busy;
    logic         done;

    logic [127:0] rkeys [0:10];
    logic [7:0]   sbox_t  [0:255];
    logic [7:0]   isbox_t [0:255];

    int n_vec;
    int n_err;

    inv_cipher_iter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ct_in  (ct_in),
        .rk     (rk),
        .rk_idx (rk_idx),
        .pt_out (pt_out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External key store: combinational lookup by the requested index.
    always_comb rk = (rk_idx <= 4'd10) ? rkeys[rk_idx] : 128'h0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] inv;
        logic [7:0] s;
        for (int i = 0; i < 256; i++) begin
            x   = 8'(i);
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                y = 8'(j);
                if (gmul(x, y) == 8'h01) inv = y;
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[i]  = s;
            isbox_t[s] = x;
        end
    endtask

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[(127 - 32 * i) -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rkeys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0] st  [0:3][0:3];
        logic [7:0] tmp [0:3][0:3];
        blk_t       cb;
        blk_t       kb;
        blk_t       ob;
        cb = ct;
        kb = rkeys[10];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = cb[4'(4 * c + r)] ^ kb[4'(4 * c + r)];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            kb = rkeys[rnd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[r][c] = isbox_t[st[r][(c - r + 4) % 4]] ^ kb[4'(4 * c + r)];
            for (int c = 0; c < 4; c++) begin
                if (rnd != 0) begin
                    st[0][c] = gmul(tmp[0][c], 8'h0e) ^ gmul(tmp[1][c], 8'h0b)
                             ^ gmul(tmp[2][c], 8'h0d) ^ gmul(tmp[3][c], 8'h09);
                    st[1][c] = gmul(tmp[0][c], 8'h09) ^ gmul(tmp[1][c], 8'h0e)
                             ^ gmul(tmp[2][c], 8'h0b) ^ gmul(tmp[3][c], 8'h0d);
                    st[2][c] = gmul(tmp[0][c], 8'h0d) ^ gmul(tmp[1][c], 8'h09)
                             ^ gmul(tmp[2][c], 8'h0e) ^ gmul(tmp[3][c], 8'h0b);
                    st[3][c] = gmul(tmp[0][c], 8'h0b) ^ gmul(tmp[1][c], 8'h0d)
                             ^ gmul(tmp[2][c], 8'h09) ^ gmul(tmp[3][c], 8'h0e);
                end else begin
                    for (int r = 0; r < 4; r++) st[r][c] = tmp[r][c];
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                ob[4'(4 * c + r)] = st[r][c];
        return ob;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("busy_done_exclusive", {127'h0, busy & done}, 128'h0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete block: latency, rk_idx sequence, result, pulse width, hold.
    task automatic run_block(input string name, input logic [127:0] ct, input logic [127:0] exp);
        int         edges;
        logic [3:0] exp_idx;
        check({name, "_idle_rk_idx"}, {124'h0, rk_idx}, 128'd10);
        ct_in = ct;
        start = 1'b1;
        step();
        start = 1'b0;
        ct_in = rand128();
        edges = 0;
        while (!done && edges <= 12) begin
            exp_idx = (edges <= 8) ? 4'(9 - edges) : ((edges == 9) ? 4'd0 : 4'd10);
            check({name, "_rk_idx"}, {124'h0, rk_idx}, {124'h0, exp_idx});
            check({name, "_busy"}, {127'h0, busy}, 128'd1);
            step();
            edges++;
        end
        check({name, "_latency"}, 128'(edges), 128'd10);
        check({name, "_pt"}, pt_out, exp);
        check({name, "_done_rk_idx"}, {124'h0, rk_idx}, 128'd10);
        check({name, "_done_busy"}, {127'h0, busy}, 128'd0);
        step();
        check({name, "_done_width"}, {127'h0, done}, 128'd0);
        check({name, "_pt_hold"}, pt_out, exp);
    endtask

    // ---------------- stimulus ----------------
    vec_t         vecs [0:NVEC-1];
    int           nd;
    int           de;
    int           d0;
    int           d1;
    int           edges;
    logic [127:0] ct_b;
    logic [127:0] exp_b;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        ct_in = 128'h0;
        build_sbox();
        key_expand(128'h0);

        step();
        step();
        check("reset_pt", pt_out, 128'h0);
        check("reset_done", {127'h0, done}, 128'd0);
        check("reset_busy", {127'h0, busy}, 128'd0);
        check("reset_rk_idx", {124'h0, rk_idx}, 128'd10);
        rst_n = 1'b1;
        step();

        vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
        vecs[1] = '{key: B_KEY,  ct: B_CT,  pt: B_PT};
        for (int i = 2; i < NVEC; i++) begin
            vecs[i].key = rand128();
            vecs[i].ct  = rand128();
            key_expand(vecs[i].key);
            vecs[i].pt  = model_decrypt(vecs[i].ct);
        end

        for (int i = 0; i < NVEC; i++) begin
            key_expand(vecs[i].key);
            run_block($sformatf("vec%0d", i), vecs[i].ct, vecs[i].pt);
        end

        // start pulses while busy must be ignored
        key_expand(C1_KEY);
        ct_in = C1_CT;
        start = 1'b1;
        step();
        start = 1'b0;
        nd = 0;
        de = -1;
        for (int e = 1; e <= 14; e++) begin
            start = (e == 3 || e == 7);
            if (start) ct_in = rand128();
            step();
            if (done) begin
                nd++;
                de = e;
            end
        end
        start = 1'b0;
        check("ignore_done_count", 128'(nd), 128'd1);
        check("ignore_latency", 128'(de), 128'd10);
        check("ignore_pt", pt_out, C1_PT);

        // start held high: back-to-back blocks
        ct_b  = rand128();
        exp_b = model_decrypt(ct_b);
        ct_in = C1_CT;
        start = 1'b1;
        step();
        edges = 0;
        nd = 0;
        d0 = 0;
        d1 = 0;
        while (nd < 2 && edges < 40) begin
            step();
            edges++;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    d0 = edges;
                    check("b2b_pt0", pt_out, C1_PT);
                    ct_in = ct_b;
                end else begin
                    d1 = edges;
                    check("b2b_pt1", pt_out, exp_b);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_done_count", 128'(nd), 128'd2);
        check("b2b_first_latency", 128'(d0), 128'd10);
        check("b2b_spacing", 128'(d1 - d0), 128'd11);
        step();
        step();
        check("b2b_idle_busy", {127'h0, busy}, 128'd0);

        // reset in the middle of a block
        ct_in = C1_CT;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {127'h0, busy}, 128'd0);
        check("midrst_pt", pt_out, 128'h0);
        check("midrst_done", {127'h0, done}, 128'd0);
        check("midrst_rk_idx", {124'h0, rk_idx}, 128'd10);
        nd = 0;
        for (int e = 0; e < 14; e++) begin
            if (e == 2) rst_n = 1'b1;
            step();
            if (done) nd++;
        end
        check("midrst_no_done", 128'(nd), 128'd0);
        run_block("post_reset", C1_CT, C1_PT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
